fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode latch.
- Owns the PC register and issues requests to instruction memory via the iREN/ihit handshake.
- Buffers returned words with their PC in a small FIFO and presents {instruction, PC, PC+4} to decode with an enable.
- Handles redirect (branch/jump) flushes and halt.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, fetch-buffer entries; legal values 2..4, power of two.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- ihit  in  1  imem response valid this cycle.
- iload  in  32  imem read data; valid when ihit.
- iREN  out  1  imem read request.
- iaddr  out  32  imem address (current PC).
- stall  in  1  hazard unit: decode latch must hold.
- redirect  in  1  branch/jump taken; flush and restart.
- redirect_pc  in  32  new fetch address; word-aligned.
- halt  in  1  halt opcode decoded.
- instru  out  32  buffer-head instruction to decode latch.
- PC  out  32  PC of buffer-head instruction.
- nPC  out  32  PC + 4 of buffer-head instruction.
- deen  out  1  decode latch enable (pop).
- flush  out  1  decode latch flush.

Behaviour:
- Reset (RST high at posedge):
  - PC register = PC_RESET; buffer count = 0; halted = 0.
  - Outputs after reset: iREN=1, iaddr=PC_RESET, deen=0, instru=0, PC=0, nPC=0, flush=0.
- Buffer:
  - Circular FIFO of {instr[31:0], pc[31:0]} with wrapping read/write pointers and a count (0..DEPTH).
  - When empty, instru/PC/nPC drive 0.
- Pop:
  - deen = (count != 0) & ~stall & ~redirect.
  - Pop occurs at the posedge where deen=1.
- Request:
  - iREN = ~halted & ~RST & ((count < DEPTH) | deen).
  - A simultaneous push and pop is allowed when full.
  - iaddr = PC register.
  - iREN stays high until ihit.
- Push:
  - At a posedge with iREN & ihit & ~redirect: write {iload, PC} at the tail, then PC <= PC + 4.
  - Latency: a word returned in cycle N is at the head, with deen possible, in cycle N+1.
- PC arithmetic:
  - 32-bit unsigned; wraps 32'hFFFF_FFFC -> 0.
  - nPC = head pc + 4, same wrap.
- Redirect (highest priority after RST):
  - flush = redirect (combinational).
  - At the posedge: buffer count = 0, pointers reset, PC <= redirect_pc.
  - Any ihit data in that cycle is discarded.
  - deen is forced 0 in that cycle.
  - halted is cleared only if it was set in the same cycle by halt (redirect wins over a halt on the wrong path).
- Halt:
  - halt & deen at a posedge sets halted (sticky until RST).
  - While halted: iREN=0, no pushes.
  - Buffer contents are frozen; deen is still allowed to drain.
- Simultaneous events:
  - stall & redirect: redirect wins.
  - push & pop on same edge: count unchanged, both pointers advance.
- Reset mid-operation:
  - Discards the in-flight request and buffer contents.
  - iREN low during the RST cycle.

Optional Feature:
- FETCH_PERF_EN: adds output ports fetch_cnt[31:0] and bubble_cnt[31:0], both reset to 0 and saturating at 32'hFFFF_FFFF.
  - fetch_cnt increments on every push.
  - bubble_cnt increments on every cycle with deen=0 & ~halted & ~RST.
- Without the macro, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then ihit tied 1, stall=0, iload = address-based pattern -> iaddr 0,4,8,...; deen first high cycle 2 with PC=0, nPC=4; one instruction per cycle after.
- ihit=1, stall held high 5 cycles from cycle 3 -> count reaches DEPTH=2, iREN=0 while full; after release, PCs 4,8,12 emerge in order, none lost or duplicated.
- Redirect with redirect_pc=32'h0000_0100 while buffer holds 2 entries and ihit=1 -> flush=1, deen=0 that cycle; next cycle iaddr=0x100; first later deen has PC=0x100.
- ihit low 3 cycles per request -> iREN held, iaddr stable at 0x8 until ihit; buffer gets exactly one entry per ihit.
- Halt popped at PC=0x10 -> iREN=0 from next cycle onward, iaddr frozen; RST pulse restarts at PC_RESET.
- PC_RESET=32'hFFFF_FFF8, ihit=1 -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; nPC of FFFF_FFFC = 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests imem words and queues them with their PC for decode.
// Optional FETCH_PERF_EN adds saturating fetch_cnt / bubble_cnt counters.
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] instru,
    output logic [31:0] PC,
    output logic [31:0] nPC,
    output logic        deen,
    output logic        flush
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             halted_q, halted_d;
    logic [63:0]      buf_q [DEPTH];
    logic [63:0]      buf_d [DEPTH];
    logic [63:0]      head;
    logic             not_empty;
    logic             push;

    always_comb begin
        not_empty = (count_q != '0);
        deen      = not_empty & ~stall & ~redirect;
        // deen in the request term lets a full buffer push and pop on the same edge
        iREN      = ~halted_q & ~RST & ((count_q < FULL) | deen);
        push      = iREN & ihit & ~redirect;
        flush     = redirect;
        iaddr     = pc_q;
        head      = buf_q[rd_ptr_q];
        instru    = not_empty ? head[63:32] : 32'h0;
        PC        = not_empty ? head[31:0] : 32'h0;
        nPC       = not_empty ? pc_inc(head[31:0]) : 32'h0;
    end

    always_comb begin
        buf_d    = buf_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // deen is already low under redirect, so a wrong-path halt can never latch
        halted_d = halted_q | (halt & deen);
        if (redirect) begin
            pc_d     = redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                buf_d[wr_ptr_q] = {iload, pc_q};
                wr_ptr_d        = wr_ptr_q + 1'b1;
                pc_d            = pc_inc(pc_q);
            end
            if (deen) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, deen})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q     <= PC_RESET;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
        buf_q <= buf_d;
    end

`ifdef FETCH_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = push ? sat_inc(fetch_cnt_q) : fetch_cnt_q;
        bubble_cnt_d = (~deen & ~halted_q) ? sat_inc(bubble_cnt_q) : bubble_cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model plus a wrap-around PC_RESET instance.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, ihit, stall, redirect, halt;
    logic [31:0] iload, redirect_pc;

    logic        iren, deen, flush;
    logic [31:0] iaddr, instru, pc_o, npc_o;
    logic        iren_w, deen_w, flush_w;
    logic [31:0] iaddr_w, instru_w, pc_w, npc_w;
`ifdef FETCH_PERF_EN
    logic [31:0] fc, bc, fc_w, bc_w;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc;
    logic [63:0] m_q[$];
    bit          m_halted;

    localparam logic [31:0] PAT = 32'h1234_0000;

    always #5 clk = ~clk;

    fetch_stage #(.PC_RESET(32'h0000_0000), .DEPTH(2)) dut (
        .CLK(clk), .RST(rst), .ihit(ihit), .iload(iload), .iREN(iren), .iaddr(iaddr),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .instru(instru), .PC(pc_o), .nPC(npc_o), .deen(deen), .flush(flush)
`ifdef FETCH_PERF_EN
        , .fetch_cnt(fc), .bubble_cnt(bc)
`endif
    );

    fetch_stage #(.PC_RESET(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
        .CLK(clk), .RST(rst), .ihit(ihit), .iload(iload), .iREN(iren_w), .iaddr(iaddr_w),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .instru(instru_w), .PC(pc_w), .nPC(npc_w), .deen(deen_w), .flush(flush_w)
`ifdef FETCH_PERF_EN
        , .fetch_cnt(fc_w), .bubble_cnt(bc_w)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: compare outputs against the model, then advance the model at the edge.
    task automatic tick(input bit chk);
        bit          e_deen, e_iren;
        logic [31:0] e_instr, e_pc, e_npc;
        #1;
        e_deen = (m_q.size() != 0) && !stall && !redirect;
        e_iren = !m_halted && !rst && ((m_q.size() < 2) || e_deen);
        if (m_q.size() != 0) begin
            e_instr = m_q[0][63:32];
            e_pc    = m_q[0][31:0];
            e_npc   = e_pc + 32'd4;
        end else begin
            e_instr = 32'h0;
            e_pc    = 32'h0;
            e_npc   = 32'h0;
        end
        if (chk) begin
            check("iREN", {31'b0, iren}, {31'b0, e_iren});
            check("iaddr", iaddr, m_pc);
            check("deen", {31'b0, deen}, {31'b0, e_deen});
            check("flush", {31'b0, flush}, {31'b0, redirect});
            check("instru", instru, e_instr);
            check("PC", pc_o, e_pc);
            check("nPC", npc_o, e_npc);
        end
        @(posedge clk);
        if (rst) begin
            m_pc     = 32'h0;
            m_q.delete();
            m_halted = 1'b0;
        end else if (redirect) begin
            m_q.delete();
            m_pc = redirect_pc;
        end else begin
            if (e_deen && halt) m_halted = 1'b1;
            if (e_deen) void'(m_q.pop_front());
            if (e_iren && ihit) begin
                m_q.push_back({iload, m_pc});
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] base_w;
        logic [31:0] r;
        base_w      = 32'hFFFF_FFF8;
        rst         = 1'b1;
        ihit        = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        halt        = 1'b0;
        iload       = 32'h0;
        redirect_pc = 32'h0;
        m_pc        = 32'h0;
        m_halted    = 1'b0;
        @(negedge clk);
        tick(0);
        tick(1);
        rst = 1'b0;

        // Streaming from reset, plus the wrap-around instance
        ihit = 1'b1;
        for (int k = 0; k < 8; k++) begin
            iload = m_pc ^ PAT;
            if (k < 4) begin
                #1;
                check("wrap_iaddr", iaddr_w, base_w + 32'(4 * k));
                if (k >= 1) begin
                    check("wrap_PC", pc_w, base_w + 32'(4 * (k - 1)));
                    check("wrap_nPC", npc_w, base_w + 32'(4 * k));
                end
            end
            tick(1);
        end

        // Stall until full, then release
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin iload = m_pc ^ PAT; tick(1); end
        stall = 1'b0;
        for (int k = 0; k < 6; k++) begin iload = m_pc ^ PAT; tick(1); end

        // Redirect with a full buffer, stall also asserted
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin iload = m_pc ^ PAT; tick(1); end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        iload       = 32'hDEAD_BEEF;
        tick(1);
        redirect = 1'b0;
        stall    = 1'b0;
        for (int k = 0; k < 5; k++) begin iload = m_pc ^ PAT; tick(1); end

        // Slow memory: three miss cycles per hit, starting at 0x8
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0008;
        tick(1);
        redirect = 1'b0;
        for (int rep = 0; rep < 4; rep++) begin
            ihit = 1'b0;
            for (int k = 0; k < 3; k++) begin iload = $urandom; tick(1); end
            ihit  = 1'b1;
            iload = m_pc ^ PAT;
            tick(1);
        end

        // Randomised traffic including resets, redirects and halts
        for (int k = 0; k < 400; k++) begin
            ihit     = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 19) == 0);
            halt     = ($urandom_range(0, 29) == 0);
            rst      = ($urandom_range(0, 49) == 0);
            r        = $urandom;
            r[1:0]   = 2'b00;
            redirect_pc = r;
            iload    = $urandom;
            tick(1);
        end
        ihit = 1'b1; stall = 1'b0; redirect = 1'b0; halt = 1'b0;

        // Halt when the instruction at 0x10 is popped; fetch freezes
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            iload = m_pc ^ PAT;
            halt  = (m_q.size() != 0) && (m_q[0][31:0] == 32'h10);
            tick(1);
        end
        halt = 1'b0;

        // Reset pulse restarts at PC_RESET
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin iload = m_pc ^ PAT; tick(1); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
